// File: rtl/vesp_mem_responder_if.sv
// Strobe/response bundle between the VeSP control FSM (master) and its memory
// responder (slave), including the A/B operand mirrors that feed the ALU.
interface vesp_mem_responder_if #(
  parameter int unsigned address_size = 12,
  parameter int unsigned word_size    = 16
);
  logic                    read;
  logic                    write;
  logic [address_size-1:0] address;
  logic [word_size-1:0]    data_in;
  logic [word_size-1:0]    data_out;
  logic                    ready;
  logic                    err;
  logic                    busy;
  logic [word_size-1:0]    A;
  logic [word_size-1:0]    B;

  modport master (
    output read, write, address, data_in,
    input  data_out, ready, err, busy, A, B
  );

  modport slave (
    input  read, write, address, data_in,
    output data_out, ready, err, busy, A, B
  );
endinterface

// File: rtl/vesp_mem_responder.sv
// VeSP memory responder: one access at a time, programmable wait states, one-cycle ready/err.
// Optional feature: define VESP_MEM_WRITE_PROTECT_EN to reject writes below protect_top.
module vesp_mem_responder #(
  parameter int unsigned address_size = 12,
  parameter int unsigned word_size    = 16,
  parameter int unsigned memory_size  = 256,
  parameter int unsigned wait_states  = 1,
  parameter int unsigned protect_top  = 2
) (
  input logic                clk,
  input logic                rst,
  vesp_mem_responder_if.slave bus
);

  localparam int unsigned IdxW     = (memory_size > 1) ? $clog2(memory_size) : 1;
  localparam logic [3:0]  WaitLoad = (wait_states > 0) ? 4'(wait_states - 1) : 4'd0;
`ifdef VESP_MEM_WRITE_PROTECT_EN
  localparam bit ProtectEn = 1'b1;
`else
  localparam bit ProtectEn = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic                    rd_q, wr_q;
  logic [address_size-1:0] addr_q;
  logic [word_size-1:0]    wdata_q;
  logic [word_size-1:0]    data_out_q, a_q, b_q;
  logic                    ready_q, err_q, busy_q;
  logic [word_size-1:0]    mem_q [memory_size];

  logic                    exec_rd_d, exec_wr_d, go_resp_d;
  logic [address_size-1:0] exec_addr_d;
  logic [word_size-1:0]    exec_data_d, data_out_d;
  logic                    in_range_d, prot_hit_d, err_d, do_write_d;
  logic [IdxW-1:0]         mem_idx_d;

  // With zero wait states the access executes on the accept edge, so the
  // operands come straight from the bus instead of the latched copies.
  always_comb begin
    exec_rd_d   = rd_q;
    exec_wr_d   = wr_q;
    exec_addr_d = addr_q;
    exec_data_d = wdata_q;
    go_resp_d   = 1'b0;
    if (state_q == IDLE) begin
      exec_rd_d   = bus.read;
      exec_wr_d   = bus.write;
      exec_addr_d = bus.address;
      exec_data_d = bus.data_in;
      go_resp_d   = (bus.read || bus.write) && (wait_states == 0);
    end else if (state_q == WAIT) begin
      go_resp_d = (cnt_q == 4'd0);
    end
    in_range_d = 32'(exec_addr_d) < memory_size;
    prot_hit_d = ProtectEn && (32'(exec_addr_d) < protect_top);
    mem_idx_d  = IdxW'(exec_addr_d);
    err_d      = (exec_rd_d && exec_wr_d) || !in_range_d || (exec_wr_d && prot_hit_d);
    do_write_d = go_resp_d && exec_wr_d && !exec_rd_d && in_range_d && !prot_hit_d;
    data_out_d = data_out_q;
    if (exec_rd_d && !exec_wr_d) begin
      data_out_d = in_range_d ? mem_q[mem_idx_d] : '0;
    end
  end

  // Array is never cleared by reset; a reset edge suppresses the pending write.
  always_ff @(posedge clk) begin
    if (!rst && do_write_d) begin
      mem_q[mem_idx_d] <= exec_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_out_q <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
    end else begin
      a_q     <= mem_q[0];
      b_q     <= mem_q[1];
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.read || bus.write) begin
            rd_q    <= bus.read;
            wr_q    <= bus.write;
            addr_q  <= bus.address;
            wdata_q <= bus.data_in;
            busy_q  <= 1'b1;
            if (go_resp_d) begin
              state_q    <= RESP;
              ready_q    <= 1'b1;
              err_q      <= err_d;
              data_out_q <= data_out_d;
            end else begin
              state_q <= WAIT;
              cnt_q   <= WaitLoad;
            end
          end
        end
        WAIT: begin
          if (go_resp_d) begin
            state_q    <= RESP;
            ready_q    <= 1'b1;
            err_q      <= err_d;
            data_out_q <= data_out_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.ready    = ready_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;
  assign bus.A        = a_q;
  assign bus.B        = b_q;

endmodule

// File: tb/tb_vesp_mem_responder.sv
// Directed bench for vesp_mem_responder: three instances with 1, 0 and 3 wait
// states, expected values hand-computed from the responder's behaviour.
module tb_vesp_mem_responder;

   localparam int AW = 12;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic rst;
   logic rst3;

   // 10 ns clock; inputs change and outputs are sampled on the falling edge
   always #5 clk = ~clk;

   vesp_mem_responder_if #(.address_size(AW), .word_size(DW)) bus1 ();
   vesp_mem_responder_if #(.address_size(AW), .word_size(DW)) bus0 ();
   vesp_mem_responder_if #(.address_size(AW), .word_size(DW)) bus3 ();

   vesp_mem_responder #(.address_size(AW), .word_size(DW), .memory_size(256),
                        .wait_states(1), .protect_top(2))
      dut1 (.clk(clk), .rst(rst), .bus(bus1));

   vesp_mem_responder #(.address_size(AW), .word_size(DW), .memory_size(256),
                        .wait_states(0), .protect_top(2))
      dut0 (.clk(clk), .rst(rst), .bus(bus0));

   vesp_mem_responder #(.address_size(AW), .word_size(DW), .memory_size(256),
                        .wait_states(3), .protect_top(2))
      dut3 (.clk(clk), .rst(rst3), .bus(bus3));

   int checkCount = 0;
   int passCount  = 0;

   // every comparison funnels through here so the summary counts stay honest
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
   endtask

   // sel picks which instance (1 or 3) an access is aimed at
   task automatic driveBus(input int sel, input logic rd, input logic wr,
                           input logic [AW-1:0] addr, input logic [DW-1:0] din);
      if (sel == 3) begin
         bus3.read = rd; bus3.write = wr; bus3.address = addr; bus3.data_in = din;
      end else begin
         bus1.read = rd; bus1.write = wr; bus1.address = addr; bus1.data_in = din;
      end
   endtask

   function automatic logic getReady(input int sel);
      return (sel == 3) ? bus3.ready : bus1.ready;
   endfunction

   function automatic logic getBusy(input int sel);
      return (sel == 3) ? bus3.busy : bus1.busy;
   endfunction

   function automatic logic getErr(input int sel);
      return (sel == 3) ? bus3.err : bus1.err;
   endfunction

   function automatic logic [DW-1:0] getData(input int sel);
      return (sel == 3) ? bus3.data_out : bus1.data_out;
   endfunction

   // one complete access: strobe for a single accept edge, then wait (bounded)
   // for the ready pulse, checking latency, busy and the pulse width on the way
   task automatic applyStimulus(input int sel, input string tag, input logic rd, input logic wr,
                                input logic [AW-1:0] addr, input logic [DW-1:0] din,
                                input int expLat, output logic [DW-1:0] dout, output logic errv);
      int lat;
      @(negedge clk);
      driveBus(sel, rd, wr, addr, din);
      @(negedge clk);
      driveBus(sel, 1'b0, 1'b0, addr, din);
      checkOutput({tag, "_busy"}, 32'(getBusy(sel)), 32'd1);
      lat = 1;
      while (getReady(sel) !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checkOutput({tag, "_latency"}, lat, expLat);
      dout = getData(sel);
      errv = getErr(sel);
      @(negedge clk);
      checkOutput({tag, "_pulse"}, 32'(getReady(sel)), 32'd0);
   endtask

   initial begin
      logic [DW-1:0] d;
      logic          e;
      int            seen;

      driveBus(1, 1'b0, 1'b0, '0, '0);
      driveBus(3, 1'b0, 1'b0, '0, '0);
      bus0.read = 1'b0; bus0.write = 1'b0; bus0.address = '0; bus0.data_in = '0;
      rst = 1'b1;
      rst3 = 1'b1;
      repeat (2) @(negedge clk);

      checkOutput("rst_data_out", 32'(bus1.data_out), 32'h0);
      checkOutput("rst_ready", 32'(bus1.ready), 32'h0);
      checkOutput("rst_err", 32'(bus1.err), 32'h0);
      checkOutput("rst_busy", 32'(bus1.busy), 32'h0);
      checkOutput("rst_A", 32'(bus1.A), 32'h0);
      checkOutput("rst_B", 32'(bus1.B), 32'h0);
      rst = 1'b0;
      rst3 = 1'b0;

      // basic write then read back, one wait state
      applyStimulus(1, "wr005", 1'b0, 1'b1, 12'h005, 16'h1234, 2, d, e);
      checkOutput("wr005_err", 32'(e), 32'h0);
      applyStimulus(1, "rd005", 1'b1, 1'b0, 12'h005, 16'h0000, 2, d, e);
      checkOutput("rd005_data", 32'(d), 32'h1234);
      checkOutput("rd005_err", 32'(e), 32'h0);

      // operand mirrors follow words 0 and 1 one cycle after RESP
      applyStimulus(1, "wrA", 1'b0, 1'b1, 12'h000, 16'h00AA, 2, d, e);
`ifdef VESP_MEM_WRITE_PROTECT_EN
      checkOutput("wrA_err", 32'(e), 32'h1);
`else
      checkOutput("wrA_err", 32'(e), 32'h0);
      checkOutput("mirror_A", 32'(bus1.A), 32'h00AA);
`endif
      applyStimulus(1, "wrB", 1'b0, 1'b1, 12'h001, 16'h0055, 2, d, e);
`ifdef VESP_MEM_WRITE_PROTECT_EN
      checkOutput("wrB_err", 32'(e), 32'h1);
`else
      checkOutput("wrB_err", 32'(e), 32'h0);
      checkOutput("mirror_B", 32'(bus1.B), 32'h0055);
      checkOutput("mirror_A_hold", 32'(bus1.A), 32'h00AA);
`endif

      // first out-of-range address
      applyStimulus(1, "rd100", 1'b1, 1'b0, 12'h100, 16'h0000, 2, d, e);
      checkOutput("rd100_err", 32'(e), 32'h1);
      checkOutput("rd100_data", 32'(d), 32'h0000);
      applyStimulus(1, "wr100", 1'b0, 1'b1, 12'h100, 16'hBEEF, 2, d, e);
      checkOutput("wr100_err", 32'(e), 32'h1);
      checkOutput("wr100_data_hold", 32'(d), 32'h0000);
`ifdef VESP_MEM_WRITE_PROTECT_EN
      applyStimulus(1, "rd005b", 1'b1, 1'b0, 12'h005, 16'h0000, 2, d, e);
      checkOutput("rd005b_data", 32'(d), 32'h1234);
`else
      applyStimulus(1, "rd000", 1'b1, 1'b0, 12'h000, 16'h0000, 2, d, e);
      checkOutput("rd000_data", 32'(d), 32'h00AA);
`endif

      // read and write together: rejected, array and data_out untouched
      applyStimulus(1, "wr003", 1'b0, 1'b1, 12'h003, 16'h3333, 2, d, e);
      checkOutput("wr003_err", 32'(e), 32'h0);
      applyStimulus(1, "rd003", 1'b1, 1'b0, 12'h003, 16'h0000, 2, d, e);
      checkOutput("rd003_data", 32'(d), 32'h3333);
      applyStimulus(1, "both003", 1'b1, 1'b1, 12'h003, 16'h9999, 2, d, e);
      checkOutput("both003_err", 32'(e), 32'h1);
      checkOutput("both003_data", 32'(d), 32'h3333);
      applyStimulus(1, "rd003b", 1'b1, 1'b0, 12'h003, 16'h0000, 2, d, e);
      checkOutput("rd003b_data", 32'(d), 32'h3333);

      // last valid word and the top of the address space
      applyStimulus(1, "wr0FF", 1'b0, 1'b1, 12'h0FF, 16'hA5A5, 2, d, e);
      checkOutput("wr0FF_err", 32'(e), 32'h0);
      applyStimulus(1, "rd0FF", 1'b1, 1'b0, 12'h0FF, 16'h0000, 2, d, e);
      checkOutput("rd0FF_data", 32'(d), 32'hA5A5);
      checkOutput("rd0FF_err", 32'(e), 32'h0);
      applyStimulus(1, "rdFFF", 1'b1, 1'b0, 12'hFFF, 16'h0000, 2, d, e);
      checkOutput("rdFFF_err", 32'(e), 32'h1);
      checkOutput("rdFFF_data", 32'(d), 32'h0000);

      // zero wait states, strobe held: ready every second cycle
      @(negedge clk);
      bus0.read = 1'b1;
      bus0.address = 12'h100;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput($sformatf("ws0_ready%0d", i), 32'(bus0.ready), (i % 2 == 0) ? 32'd1 : 32'd0);
         checkOutput($sformatf("ws0_busy%0d", i), 32'(bus0.busy), (i % 2 == 0) ? 32'd1 : 32'd0);
         if (i % 2 == 0) checkOutput($sformatf("ws0_err%0d", i), 32'(bus0.err), 32'd1);
      end
      bus0.read = 1'b0;
      @(negedge clk);
      checkOutput("ws0_ready_after", 32'(bus0.ready), 32'd0);

      // three wait states: seed a value, then reset in the middle of an overwrite
      applyStimulus(3, "ws3_wr010", 1'b0, 1'b1, 12'h010, 16'h0F0F, 4, d, e);
      checkOutput("ws3_wr010_err", 32'(e), 32'h0);
      @(negedge clk);
      driveBus(3, 1'b0, 1'b1, 12'h010, 16'hDEAD);
      @(negedge clk);
      driveBus(3, 1'b0, 1'b0, 12'h010, 16'hDEAD);
      checkOutput("ws3_busy_wait", 32'(bus3.busy), 32'd1);
      rst3 = 1'b1;
      @(negedge clk);
      checkOutput("ws3_rst_busy", 32'(bus3.busy), 32'd0);
      checkOutput("ws3_rst_ready", 32'(bus3.ready), 32'd0);
      rst3 = 1'b0;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus3.ready === 1'b1) seen = 1;
      end
      checkOutput("ws3_no_ready", seen, 0);
      applyStimulus(3, "ws3_rd010", 1'b1, 1'b0, 12'h010, 16'h0000, 4, d, e);
      checkOutput("ws3_rd010_data", 32'(d), 32'h0F0F);
      checkOutput("ws3_rd010_err", 32'(e), 32'h0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   // absolute time bound in case the sequence above ever stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", checkCount);
      $fatal(1, "[TB] time limit");
   end

endmodule
